// File: rtl/user_gpio_pkg.sv
// user_gpio_pkg: register offsets, window size and pin-to-irq-channel mask helper
package user_gpio_pkg;
  localparam int ADR_WIN_BITS = 6;
  localparam logic [5:0] OUT_LO      = 6'h00;
  localparam logic [5:0] OUT_HI      = 6'h04;
  localparam logic [5:0] OEB_LO      = 6'h08;
  localparam logic [5:0] OEB_HI      = 6'h0C;
  localparam logic [5:0] LOOP_LO     = 6'h10;
  localparam logic [5:0] LOOP_HI     = 6'h14;
  localparam logic [5:0] IN_LO       = 6'h18;
  localparam logic [5:0] IN_HI       = 6'h1C;
  localparam logic [5:0] IRQ_EN_LO   = 6'h20;
  localparam logic [5:0] IRQ_EN_HI   = 6'h24;
  localparam logic [5:0] IRQ_STAT_LO = 6'h28;
  localparam logic [5:0] IRQ_STAT_HI = 6'h2C;
  function automatic logic [63:0] irq_mask(input int num_io, input int irq_ch, input int k);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < 64; i++) m[i] = (i < num_io) && (i % irq_ch == k);
    return m;
  endfunction
endpackage

// File: rtl/user_gpio_sync.sv
// user_gpio_sync: two-flop input synchroniser plus delay flop for rising-edge detect
module user_gpio_sync #(
  parameter int N = 38
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] d,
  output logic [N-1:0] in_s,
  output logic [N-1:0] rise
);
  logic [N-1:0] m, in_d;
  always_ff @(posedge clk) begin
    m    <= rst ? '0 : d;
    in_s <= rst ? '0 : m;
    in_d <= rst ? '0 : in_s;
  end
  assign rise = in_s & ~in_d;
endmodule

// File: rtl/user_gpio_ctrl.sv
// user_gpio_ctrl: Wishbone GPIO engine (loopback/register outputs, OEB, edge IRQs); option USER_GPIO_LA_OVERRIDE_EN lets LA drive pads
module user_gpio_ctrl
  import user_gpio_pkg::*;
#(
  parameter int          NUM_IO   = 38,
  parameter logic [31:0] BASE_ADR = 32'h3000_0000,
  parameter int          IRQ_CH   = 3
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  input  logic [NUM_IO-1:0] io_in,
  output logic [NUM_IO-1:0] io_out,
  output logic [NUM_IO-1:0] io_oeb,
  input  logic [127:0]      la_data_in,
  input  logic [127:0]      la_oenb,
  output logic [127:0]      la_data_out,
  output logic [IRQ_CH-1:0] user_irq
);
  localparam logic [63:0] PM = {64{1'b1}} >> (64 - NUM_IO);
  logic [NUM_IO-1:0] in_s, rise, mux, io_nxt;
  logic [63:0] s64, out_r, oeb_r, loop_r, ien_r, stat_r, out_n, oeb_n, loop_n, ien_n, stat_n, wm, wd;
  logic [31:0] wm32, rdata;
  logic [IRQ_CH-1:0] irq_n;
  logic [5:0] off;
  logic hit, wr, unused_ok;
  user_gpio_sync #(.N(NUM_IO)) u_sync (.clk(wb_clk_i), .rst(wb_rst_i), .d(io_in), .in_s(in_s), .rise(rise));
  assign s64  = 64'(in_s);
  assign off  = wbs_adr_i[5:0];
  assign hit  = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:ADR_WIN_BITS] == BASE_ADR[31:ADR_WIN_BITS]);
  assign wr   = hit & wbs_ack_o & wbs_we_i;
  assign wm32 = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
  assign wm   = off[2] ? {wm32, 32'h0} : {32'h0, wm32};
  assign wd   = {wbs_dat_i, wbs_dat_i};
  always_comb begin
    out_n  = (wr && off[5:3] == OUT_LO[5:3]) ? ((out_r & ~wm) | (wd & wm)) & PM : out_r;
    oeb_n  = (wr && off[5:3] == OEB_LO[5:3]) ? ((oeb_r & ~wm) | (wd & wm)) & PM : oeb_r;
    loop_n = (wr && off[5:3] == LOOP_LO[5:3]) ? ((loop_r & ~wm) | (wd & wm)) & PM : loop_r;
    ien_n  = (wr && off[5:3] == IRQ_EN_LO[5:3]) ? ((ien_r & ~wm) | (wd & wm)) & PM : ien_r;
    stat_n = ((wr && off[5:3] == IRQ_STAT_LO[5:3]) ? stat_r & ~(wd & wm) : stat_r) | s64 & 64'(rise);
    mux    = (loop_n[NUM_IO-1:0] & in_s) | (~loop_n[NUM_IO-1:0] & out_n[NUM_IO-1:0]);
    rdata  = '0;
    case ({off[5:2], 2'b00})
      OUT_LO:      rdata = out_r[31:0];
      OUT_HI:      rdata = out_r[63:32];
      OEB_LO:      rdata = oeb_r[31:0];
      OEB_HI:      rdata = oeb_r[63:32];
      LOOP_LO:     rdata = loop_r[31:0];
      LOOP_HI:     rdata = loop_r[63:32];
      IN_LO:       rdata = s64[31:0];
      IN_HI:       rdata = s64[63:32];
      IRQ_EN_LO:   rdata = ien_r[31:0];
      IRQ_EN_HI:   rdata = ien_r[63:32];
      IRQ_STAT_LO: rdata = stat_r[31:0];
      IRQ_STAT_HI: rdata = stat_r[63:32];
      default:     rdata = '0;
    endcase
  end
  for (genvar k = 0; k < IRQ_CH; k++) begin : g_irq
    assign irq_n[k] = |(stat_r & ien_r & irq_mask(NUM_IO, IRQ_CH, k));
  end
`ifdef USER_GPIO_LA_OVERRIDE_EN
  assign io_nxt      = (~la_oenb[NUM_IO-1:0] & la_data_in[NUM_IO-1:0]) | (la_oenb[NUM_IO-1:0] & mux);
  assign la_data_out = 128'(in_s);
  assign unused_ok   = ^{wbs_adr_i[1:0], la_data_in[127:NUM_IO], la_oenb[127:NUM_IO]};
`else
  assign io_nxt      = mux;
  assign la_data_out = '0;
  assign unused_ok   = ^{wbs_adr_i[1:0], la_data_in, la_oenb};
`endif
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      out_r     <= '0;
      oeb_r     <= PM;
      loop_r    <= '0;
      ien_r     <= '0;
      stat_r    <= '0;
      io_out    <= '0;
      io_oeb    <= '1;
      user_irq  <= '0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      out_r     <= out_n;
      oeb_r     <= oeb_n;
      loop_r    <= loop_n;
      ien_r     <= ien_n;
      stat_r    <= stat_n;
      io_out    <= io_nxt;
      io_oeb    <= oeb_n[NUM_IO-1:0];
      user_irq  <= irq_n;
      wbs_ack_o <= hit & ~wbs_ack_o;
      wbs_dat_o <= (hit & ~wbs_ack_o) ? rdata : '0;
    end
  end
endmodule
